// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte producers
// Optional feature macro UART_ARB_LOCK_EN adds req_lock so a requester can hold the grant.
module uart_tx_arbiter #(
    parameter int  N_REQ    = 4,
    parameter int  DATA_W   = 8,
    parameter int  BUSY_TMO = 16,
    localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TMO_W    = $clog2(BUSY_TMO)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_start,
    input  logic                      tx_busy,
    output logic [ID_W-1:0]           grant_id,
    output logic                      ctrl_busy,
`ifdef UART_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          req_lock,
`endif
    output logic                      err_tmo
);

    localparam int IDX_W = ID_W + 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   sel;
    logic [IDX_W-1:0]  idx;
    logic              found;
    logic              accept;
    logic              tmo_hit;
    logic [TMO_W-1:0]  tmo_cnt;
`ifdef UART_ARB_LOCK_EN
    logic              lock_act;
`endif

    // Scan downwards so the requester closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + IDX_W'(k);
            if (idx >= IDX_W'(N_REQ)) begin
                idx = idx - IDX_W'(N_REQ);
            end
            if (req_valid[idx[ID_W-1:0]]) begin
                found = 1'b1;
                sel   = idx[ID_W-1:0];
            end
        end
`ifdef UART_ARB_LOCK_EN
        if (lock_act) begin
            found = req_valid[grant_id];
            sel   = grant_id;
        end
`endif
    end

    assign accept    = (state == IDLE) && !tx_busy && found;
    assign tmo_hit   = (state == WAIT_BUSY) && !tx_busy && (tmo_cnt == TMO_W'(BUSY_TMO - 1));
    assign ctrl_busy = (state != IDLE);

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[sel] = 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (accept) state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_nxt = WAIT_DONE;
                end else if (tmo_hit) begin
                    state_nxt = IDLE;
                end
            end
            WAIT_DONE: if (!tx_busy) state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr_ptr   <= '0;
            tmo_cnt  <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            grant_id <= '0;
            err_tmo  <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock_act <= 1'b0;
`endif
        end else begin
            state    <= state_nxt;
            tx_start <= accept;
            err_tmo  <= tmo_hit;
            if (accept) begin
                tx_data  <= req_data[int'(sel)*DATA_W +: DATA_W];
                grant_id <= sel;
                rr_ptr   <= (sel == ID_W'(N_REQ - 1)) ? '0 : sel + 1'b1;
                tmo_cnt  <= '0;
`ifdef UART_ARB_LOCK_EN
                lock_act <= req_lock[sel];
`endif
            end else if (state == WAIT_BUSY) begin
                // Holds at the terminal count; cleared again once back in IDLE.
                if (tmo_cnt != TMO_W'(BUSY_TMO - 1)) begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                end
            end else begin
                tmo_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - scoreboard bench for uart_tx_arbiter with a simple uart_tx model
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;
    localparam int BIT = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   tx_data;
    logic            tx_start;
    logic            tx_busy = 1'b0;
    logic [1:0]      grant_id;
    logic            ctrl_busy;
    logic            err_tmo;
`ifdef UART_ARB_LOCK_EN
    logic [N-1:0]    req_lock = '0;
`endif

    uart_tx_arbiter #(.N_REQ(N), .DATA_W(DW), .BUSY_TMO(TMO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .grant_id(grant_id), .ctrl_busy(ctrl_busy),
`ifdef UART_ARB_LOCK_EN
        .req_lock(req_lock),
`endif
        .err_tmo(err_tmo)
    );

    always #5 clk = ~clk;

    // uart_tx model: 8N1 frame, BIT cycles per bit, busy rises the cycle after start.
    logic       model_en = 1'b1;
    logic [9:0] shreg = '0;
    logic [9:0] cur_frame = '0;
    logic [9:0] last_frame = '0;
    int         bit_i = 0;
    int         bcyc = 0;
    int         frames = 0;
    logic       txd;

    assign txd = tx_busy ? shreg[bit_i] : 1'b1;

    always @(posedge clk) begin
        if (rst) begin
            tx_busy <= 1'b0;
            bit_i   <= 0;
            bcyc    <= 0;
        end else if (!tx_busy) begin
            if (tx_start && model_en) begin
                tx_busy <= 1'b1;
                shreg   <= {1'b1, tx_data, 1'b0};
                bit_i   <= 0;
                bcyc    <= 0;
            end
        end else if (bcyc == BIT - 1) begin
            bcyc <= 0;
            cur_frame[bit_i] <= txd;
            if (bit_i == 9) begin
                tx_busy    <= 1'b0;
                frames     <= frames + 1;
                last_frame <= {txd, cur_frame[8:0]};
            end else begin
                bit_i <= bit_i + 1;
            end
        end else begin
            bcyc <= bcyc + 1;
        end
    end

    logic [8:0] src_q [N][$];
    logic [9:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_start = 0;
    int n_tmo = 0;
    int last_start_cyc = 0;
    int last_tmo_cyc = 0;
    int rdy_cyc [N];

    task automatic refresh();
        logic [8:0] f;
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() > 0) begin
                f = src_q[i][0];
                req_valid[i]          = 1'b1;
                req_data[i*DW +: DW]  = f[7:0];
`ifdef UART_ARB_LOCK_EN
                req_lock[i]           = f[8];
`endif
            end else begin
                req_valid[i]          = 1'b0;
                req_data[i*DW +: DW]  = '0;
`ifdef UART_ARB_LOCK_EN
                req_lock[i]           = 1'b0;
`endif
            end
        end
    endtask

    function automatic bit queues_empty();
        for (int i = 0; i < N; i++) begin
            if (src_q[i].size() != 0) return 1'b0;
        end
        return 1'b1;
    endfunction

    // One clock: sample at negedge (scoreboard pop on tx_start), advance, pop accepted bytes.
    task automatic tick();
        logic [N-1:0] acc;
        logic [9:0]   e;
        @(negedge clk);
        cyc++;
        acc = req_valid & req_ready;
        for (int i = 0; i < N; i++) rdy_cyc[i] += int'(req_ready[i]);
        if (tx_start) begin
            n_start++;
            last_start_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_extra: got id=%0d data=%02h, required no start", grant_id, tx_data);
            end else begin
                e = exp_q.pop_front();
                if ({grant_id, tx_data} !== e) begin
                    bad++;
                    $display("FAIL sb_order: got id=%0d data=%02h, required id=%0d data=%02h",
                             grant_id, tx_data, e[9:8], e[7:0]);
                end
            end
            total++;
            if (tx_busy !== 1'b0) begin
                bad++;
                $display("FAIL start_overlap: tx_busy=%b at tx_start, required 0", tx_busy);
            end
        end
        if (err_tmo) begin
            n_tmo++;
            last_tmo_cyc = cyc;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) void'(src_q[i].pop_front());
        end
        refresh();
    endtask

    task automatic run_idle(input int max, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (exp_q.size() == 0 && !ctrl_busy && !tx_busy && queues_empty()) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        for (int i = 0; i < N; i++) src_q[i].delete();
        exp_q.delete();
        refresh();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < N; i++) rdy_cyc[i] = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) rdy_cyc[i] = 0;
        rst = 1'b1;
        tick();
        tick();
        total++; if (tx_data !== 8'h00)   begin bad++; $display("FAIL rst_tx_data: got %02h, required 00", tx_data); end
        total++; if (tx_start !== 1'b0)   begin bad++; $display("FAIL rst_tx_start: got %b, required 0", tx_start); end
        total++; if (req_ready !== 4'h0)  begin bad++; $display("FAIL rst_req_ready: got %b, required 0000", req_ready); end
        total++; if (grant_id !== 2'd0)   begin bad++; $display("FAIL rst_grant_id: got %0d, required 0", grant_id); end
        total++; if (ctrl_busy !== 1'b0)  begin bad++; $display("FAIL rst_ctrl_busy: got %b, required 0", ctrl_busy); end
        total++; if (err_tmo !== 1'b0)    begin bad++; $display("FAIL rst_err_tmo: got %b, required 0", err_tmo); end
        rst = 1'b0;
    endtask

    task automatic test_single();
        bit ok;
        int f0 = frames;
        int s0 = n_start;
        src_q[1].push_back({1'b0, 8'hA5});
        exp_q.push_back({2'd1, 8'hA5});
        refresh();
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (frames != f0) begin
                ok = 1'b1;
                break;
            end
        end
        total++; if (!ok) begin bad++; $display("FAIL single_frame_wait: got no frame, required one within 200 cycles"); end
        total++; if (last_frame !== 10'b1101001010) begin bad++; $display("FAIL single_serial: got %b, required 1101001010", last_frame); end
        total++; if (ctrl_busy !== 1'b1) begin bad++; $display("FAIL single_busy_at_fall: got %b, required 1", ctrl_busy); end
        tick();
        total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL single_busy_after: got %b, required 0", ctrl_busy); end
        total++; if (rdy_cyc[1] !== 1) begin bad++; $display("FAIL single_ready_cycles: got %0d, required 1", rdy_cyc[1]); end
        total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL single_starts: got %0d, required 1", n_start - s0); end
    endtask

    task automatic test_round_robin();
        bit ok;
        int s0;
        apply_reset();
        s0 = n_start;
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < N; i++) begin
                src_q[i].push_back({1'b0, 8'h10 + 8'(i)});
                exp_q.push_back({2'(i), 8'h10 + 8'(i)});
            end
        end
        refresh();
        run_idle(2000, ok);
        total++; if (!ok) begin bad++; $display("FAIL rr_drain: got %0d pending, required 0", exp_q.size()); end
        total++; if (n_start - s0 !== 8) begin bad++; $display("FAIL rr_starts: got %0d, required 8", n_start - s0); end
    endtask

    task automatic test_timeout();
        int s0;
        int t0;
        apply_reset();
        model_en = 1'b0;
        s0 = n_start;
        t0 = n_tmo;
        src_q[0].push_back({1'b0, 8'h5A});
        exp_q.push_back({2'd0, 8'h5A});
        refresh();
        for (int i = 0; i < 60; i++) tick();
        total++; if (n_tmo - t0 !== 1) begin bad++; $display("FAIL tmo_pulses: got %0d, required 1", n_tmo - t0); end
        total++; if (last_tmo_cyc - last_start_cyc !== TMO) begin bad++; $display("FAIL tmo_latency: got %0d, required %0d", last_tmo_cyc - last_start_cyc, TMO); end
        total++; if (n_start - s0 !== 1) begin bad++; $display("FAIL tmo_no_retry: got %0d starts, required 1", n_start - s0); end
        total++; if (rdy_cyc[0] !== 1) begin bad++; $display("FAIL tmo_ready_cycles: got %0d, required 1", rdy_cyc[0]); end
        total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL tmo_idle: got %b, required 0", ctrl_busy); end
        model_en = 1'b1;
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        apply_reset();
        src_q[1].push_back({1'b0, 8'h77});
        exp_q.push_back({2'd1, 8'h77});
        refresh();
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (tx_busy && ctrl_busy) begin
                ok = 1'b1;
                break;
            end
        end
        tick();
        total++; if (!ok || ctrl_busy !== 1'b1) begin bad++; $display("FAIL mid_reach_wait_done: got busy=%b, required 1", ctrl_busy); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++; if (tx_start !== 1'b0)  begin bad++; $display("FAIL mid_tx_start: got %b, required 0", tx_start); end
        total++; if (req_ready !== 4'h0) begin bad++; $display("FAIL mid_req_ready: got %b, required 0000", req_ready); end
        total++; if (ctrl_busy !== 1'b0) begin bad++; $display("FAIL mid_ctrl_busy: got %b, required 0", ctrl_busy); end
        total++; if (grant_id !== 2'd0)  begin bad++; $display("FAIL mid_grant_id: got %0d, required 0", grant_id); end
        src_q[2].push_back({1'b0, 8'h22});
        src_q[0].push_back({1'b0, 8'h20});
        exp_q.push_back({2'd0, 8'h20});
        exp_q.push_back({2'd2, 8'h22});
        refresh();
        run_idle(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL mid_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

    task automatic test_wrap();
        bit ok;
        apply_reset();
        src_q[3].push_back({1'b0, 8'h33});
        exp_q.push_back({2'd3, 8'h33});
        refresh();
        run_idle(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_first: got %0d pending, required 0", exp_q.size()); end
        src_q[0].push_back({1'b0, 8'h40});
        src_q[3].push_back({1'b0, 8'h43});
        exp_q.push_back({2'd0, 8'h40});
        exp_q.push_back({2'd3, 8'h43});
        refresh();
        run_idle(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL wrap_drain: got %0d pending, required 0", exp_q.size()); end
    endtask

`ifdef UART_ARB_LOCK_EN
    task automatic test_lock();
        bit ok;
        apply_reset();
        src_q[1].push_back({1'b0, 8'h01});
        exp_q.push_back({2'd1, 8'h01});
        refresh();
        run_idle(500, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_setup: got %0d pending, required 0", exp_q.size()); end
        for (int i = 0; i < N; i++) rdy_cyc[i] = 0;
        src_q[2].push_back({1'b1, 8'hC0});
        src_q[2].push_back({1'b1, 8'hC1});
        src_q[2].push_back({1'b0, 8'hC2});
        src_q[0].push_back({1'b0, 8'h0A});
        exp_q.push_back({2'd2, 8'hC0});
        exp_q.push_back({2'd2, 8'hC1});
        exp_q.push_back({2'd2, 8'hC2});
        exp_q.push_back({2'd0, 8'h0A});
        refresh();
        run_idle(1000, ok);
        total++; if (!ok) begin bad++; $display("FAIL lock_drain: got %0d pending, required 0", exp_q.size()); end
        total++; if (rdy_cyc[0] !== 1) begin bad++; $display("FAIL lock_req0_ready: got %0d cycles, required 1", rdy_cyc[0]); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_reset_mid_frame();
        test_wrap();
`ifdef UART_ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
